ps2_command_transmitter: RTL
============================

// Module: ps2_command_transmitter
// PURPOSE
//   Host-to-device half of the PS/2 link: sends one 8-bit command byte (e.g. 0xED set-LEDs,
//   0xFF reset) to a keyboard/mouse. Inhibits the bus, issues the request-to-send, and shifts
//   data/parity/stop on device-generated clock edges. Checks for the device ACK.
//   Sits beside the PS/2 receive path and shares the PS2_CLK/PS2_DAT open-drain pads.
// PARAMETERS
//   INHIBIT_CYCLES   6000    CLOCK_50 cycles CLK held low before RTS (120 us @ 50 MHz)
//   START_TIMEOUT    750000  max cycles from RTS to first device falling edge (15 ms)
//   XFER_TIMEOUT     100000  max cycles from first falling edge to ACK (2 ms)
// PORTS
//   CLOCK_50              in   1  system clock
//   reset_n               in   1  asynchronous, active-low reset
//   command               in   8  byte to transmit; sampled in the cycle send_command=1
//   send_command          in   1  1-cycle start strobe; ignored while busy=1
//   busy                  out  1  1 from accepted strobe until done/error pulse cycle incl.
//   command_was_sent      out  1  1-cycle pulse: device ACKed and bus returned idle
//   error_timed_out       out  1  1-cycle pulse: START_/XFER_TIMEOUT expired
//   ps2_clk_in            in   1  raw PS2_CLK pad level (asynchronous)
//   ps2_dat_in            in   1  raw PS2_DAT pad level (asynchronous)
//   ps2_clk_drive_low     out  1  1 = pull PS2_CLK low; 0 = release (pad is 1'bz)
//   ps2_dat_drive_low     out  1  1 = pull PS2_DAT low; 0 = release
// BEHAVIOUR
//   Reset: all outputs 0 (both lines released), FSM IDLE, counters 0; reset_n low
//   mid-transfer releases lines asynchronously at once.
//   Inputs pass a 2-flop synchroniser; falling edge = prev sync 1, now sync 0 (1-cycle pulse).
//   Frame: start(0), D0..D7 LSB first, odd parity (~^command), stop(1), device ACK(0).
//   FSM:
//   IDLE     send_command=1 -> latch command, compute parity, busy=1, -> INHIBIT.
//   INHIBIT  clk_drive_low=1 for INHIBIT_CYCLES; then dat_drive_low=1 (start bit), same
//            cycle clk_drive_low=0 -> WAIT_CLK; timer cleared.
//   WAIT_CLK first falling edge -> drive D0 (dat_drive_low=~D0), bit_cnt=1 -> DATA;
//            timer>=START_TIMEOUT-1 -> ERROR.
//   DATA     each falling edge: bit_cnt 1..7 drive D1..D7, 8 drive parity, 9 release DAT
//            (stop); bit_cnt++. At falling edge with bit_cnt=10 -> sample synced DAT:
//            0 -> WAIT_IDLE; 1 (no ACK) -> ERROR. timer >= XFER_TIMEOUT-1 -> ERROR.
//   WAIT_IDLE both synced lines 1 -> DONE; XFER_TIMEOUT still applies -> ERROR.
//   DONE     command_was_sent=1 one cycle, busy=1 this cycle -> IDLE.
//   ERROR    both lines released, error_timed_out=1 one cycle -> IDLE.
//   Data changes only in the cycle after a detected falling edge (CLK low); never while high.
//   Timer: 20-bit saturating up-counter, cleared on every state entry except DATA->DATA.
//   send_command while busy: dropped, no queueing. Simultaneous timeout and edge: timeout wins.
//   command_was_sent and error_timed_out are mutually exclusive; one per accepted command.
//   Does not filter received bytes; device reply (0xFA) is left to the receive path.
// STRUCTURE
//   ps2_pkg: state enum (IDLE, INHIBIT, WAIT_CLK, DATA, WAIT_IDLE, DONE, ERROR),
//   default timing constants, frame bit positions (PARITY_BIT=8, STOP_BIT=9, ACK_BIT=10).
//   Sub-module ps2_line_sync: 2-flop synchroniser + falling-edge pulse, one per line.
//   Top: FSM, 4-bit bit counter, 20-bit timer, 8-bit shift register, parity flop.
// TESTING  (bench: INHIBIT_CYCLES=20, START_TIMEOUT=400, XFER_TIMEOUT=2000; device BFM
//   clock period 80 cycles, samples DAT on rising edges)
//   1 send 0xED -> CLK low 20 cycles, BFM reads 0,1,0,1,1,0,1,1,1, parity 1, stop 1; BFM ACK
//     -> command_was_sent 1 pulse after lines idle, busy 0 next cycle.
//   2 send 0xFF -> parity bit 1... (eight ones: parity 1); 0x00 -> parity 1; 0x01 -> parity 0.
//   3 BFM never clocks -> error_timed_out pulse exactly 400 cycles after RTS, lines released.
//   4 BFM omits ACK (DAT high on 11th edge) -> error_timed_out, no command_was_sent.
//   5 send_command re-pulsed with 0x12 during DATA -> ignored; BFM still receives first byte.
//   6 reset_n low in bit 4 -> both drive_low=0 same cycle (async), busy=0; next send 0xF4 OK.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device command transmitter.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    WAIT_CLK,
    DATA,
    WAIT_IDLE,
    DONE,
    ERROR
  } ps2_state_e;

  localparam int DEF_INHIBIT_CYCLES = 6000;
  localparam int DEF_START_TIMEOUT  = 750000;
  localparam int DEF_XFER_TIMEOUT   = 100000;

  // bit_cnt value at the falling edge that drives/samples each frame slot
  localparam logic [3:0] PARITY_BIT = 4'd8;
  localparam logic [3:0] STOP_BIT   = 4'd9;
  localparam logic [3:0] ACK_BIT    = 4'd10;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for one PS/2 pad plus a single-cycle falling-edge pulse.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic line_sync,
  output logic line_fall
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Synchroniser chain and edge history; an idle PS/2 line reads high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
      prev_r <= 1'b1;
    end else begin
      meta_r <= line_in;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign line_sync = sync_r;
  assign line_fall = prev_r & ~sync_r;

endmodule

// File: rtl/ps2_command_transmitter.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, shift on device
// clock falling edges, check ACK, report done or timeout.
module ps2_command_transmitter
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int START_TIMEOUT  = DEF_START_TIMEOUT,
  parameter int XFER_TIMEOUT   = DEF_XFER_TIMEOUT
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic [7:0] command,
  input  logic       send_command,
  output logic       busy,
  output logic       command_was_sent,
  output logic       error_timed_out,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_dat_drive_low
);

  localparam logic [19:0] INHIBIT_LIM = 20'(INHIBIT_CYCLES - 1);
  localparam logic [19:0] START_LIM   = 20'(START_TIMEOUT - 1);
  localparam logic [19:0] XFER_LIM    = 20'(XFER_TIMEOUT - 1);

  ps2_state_e  state_r, state_nxt;
  logic [19:0] timer_r;
  logic [3:0]  bit_cnt_r, bit_cnt_nxt;
  logic [7:0]  shift_r, shift_nxt;
  logic        parity_r, parity_nxt;
  logic        clk_low_r, clk_low_nxt;
  logic        dat_low_r, dat_low_nxt;
  logic        busy_r, busy_nxt;
  logic        sent_r, sent_nxt;
  logic        err_r, err_nxt;
  logic        timer_clr_s;
  logic        clk_sync_s, clk_fall_s;
  logic        dat_sync_s, dat_fall_s;

  ps2_line_sync u_clk_sync (
    .clk       (CLOCK_50),
    .rst_n     (reset_n),
    .line_in   (ps2_clk_in),
    .line_sync (clk_sync_s),
    .line_fall (clk_fall_s)
  );

  ps2_line_sync u_dat_sync (
    .clk       (CLOCK_50),
    .rst_n     (reset_n),
    .line_in   (ps2_dat_in),
    .line_sync (dat_sync_s),
    .line_fall (dat_fall_s)
  );

  // State register and registered datapath/outputs; reset releases both pads at once.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      bit_cnt_r <= 4'd0;
      shift_r   <= 8'd0;
      parity_r  <= 1'b0;
      clk_low_r <= 1'b0;
      dat_low_r <= 1'b0;
      busy_r    <= 1'b0;
      sent_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      bit_cnt_r <= bit_cnt_nxt;
      shift_r   <= shift_nxt;
      parity_r  <= parity_nxt;
      clk_low_r <= clk_low_nxt;
      dat_low_r <= dat_low_nxt;
      busy_r    <= busy_nxt;
      sent_r    <= sent_nxt;
      err_r     <= err_nxt;
    end
  end

  assign timer_clr_s = (state_nxt != state_r) || (state_r == IDLE);

  // Saturating phase timer, restarted on every state entry.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      timer_r <= 20'd0;
    end else if (timer_clr_s) begin
      timer_r <= 20'd0;
    end else if (timer_r != 20'hFFFFF) begin
      timer_r <= timer_r + 20'd1;
    end else begin
      timer_r <= timer_r;
    end
  end

  // Next-state and next-output logic; timeouts take priority over clock edges.
  always_comb begin
    state_nxt   = state_r;
    bit_cnt_nxt = bit_cnt_r;
    shift_nxt   = shift_r;
    parity_nxt  = parity_r;
    clk_low_nxt = 1'b0;
    dat_low_nxt = dat_low_r;
    busy_nxt    = 1'b1;
    sent_nxt    = 1'b0;
    err_nxt     = 1'b0;
    case (state_r)
      IDLE: begin
        dat_low_nxt = 1'b0;
        if (send_command) begin
          state_nxt   = INHIBIT;
          clk_low_nxt = 1'b1;
          shift_nxt   = command;
          parity_nxt  = odd_parity(command);
          bit_cnt_nxt = 4'd0;
        end else begin
          busy_nxt = 1'b0;
        end
      end
      INHIBIT: begin
        if (timer_r >= INHIBIT_LIM) begin
          state_nxt   = WAIT_CLK;
          dat_low_nxt = 1'b1;
        end else begin
          clk_low_nxt = 1'b1;
        end
      end
      WAIT_CLK: begin
        if (timer_r >= START_LIM) begin
          state_nxt   = ERROR;
          dat_low_nxt = 1'b0;
          err_nxt     = 1'b1;
        end else if (clk_fall_s) begin
          state_nxt   = DATA;
          dat_low_nxt = ~shift_r[0];
          shift_nxt   = {1'b0, shift_r[7:1]};
          bit_cnt_nxt = 4'd1;
        end else begin
          state_nxt = WAIT_CLK;
        end
      end
      DATA: begin
        if (timer_r >= XFER_LIM) begin
          state_nxt   = ERROR;
          dat_low_nxt = 1'b0;
          err_nxt     = 1'b1;
        end else if (clk_fall_s) begin
          bit_cnt_nxt = bit_cnt_r + 4'd1;
          if (bit_cnt_r < PARITY_BIT) begin
            dat_low_nxt = ~shift_r[0];
            shift_nxt   = {1'b0, shift_r[7:1]};
          end else if (bit_cnt_r == PARITY_BIT) begin
            dat_low_nxt = ~parity_r;
          end else if (bit_cnt_r == STOP_BIT) begin
            dat_low_nxt = 1'b0;
          end else if ((bit_cnt_r == ACK_BIT) && !dat_sync_s) begin
            bit_cnt_nxt = bit_cnt_r;
            state_nxt   = WAIT_IDLE;
          end else begin
            bit_cnt_nxt = bit_cnt_r;
            dat_low_nxt = 1'b0;
            state_nxt   = ERROR;
            err_nxt     = 1'b1;
          end
        end else begin
          state_nxt = DATA;
        end
      end
      WAIT_IDLE: begin
        dat_low_nxt = 1'b0;
        if (timer_r >= XFER_LIM) begin
          state_nxt = ERROR;
          err_nxt   = 1'b1;
        end else if (clk_sync_s && dat_sync_s && !dat_fall_s) begin
          state_nxt = DONE;
          sent_nxt  = 1'b1;
        end else begin
          state_nxt = WAIT_IDLE;
        end
      end
      DONE: begin
        state_nxt   = IDLE;
        dat_low_nxt = 1'b0;
        busy_nxt    = 1'b0;
      end
      ERROR: begin
        state_nxt   = IDLE;
        dat_low_nxt = 1'b0;
        busy_nxt    = 1'b0;
      end
      default: begin
        state_nxt   = IDLE;
        dat_low_nxt = 1'b0;
        busy_nxt    = 1'b0;
      end
    endcase
  end

  assign busy              = busy_r;
  assign command_was_sent  = sent_r;
  assign error_timed_out   = err_r;
  assign ps2_clk_drive_low = clk_low_r;
  assign ps2_dat_drive_low = dat_low_r;

endmodule
